// File: rtl/sdram_arb.sv
// rtl/sdram_arb.sv - SDRAM refresh/read/write arbiter; optional write aging via SDRAM_ARB_WR_AGE_EN
module sdram_arb #(
   parameter int REF_INTERVAL = 1500,
   parameter int WR_MAX_WAIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_req,
   input  logic [23:0] rd_addr,
   output logic        rd_gnt,
   input  logic        wr_req,
   input  logic [23:0] wr_addr,
   output logic        wr_gnt,
   output logic        seq_start,
   output logic [1:0]  seq_op,
   output logic [23:0] seq_addr,
   input  logic        seq_done,
   output logic        busy,
   output logic        ref_ovf
);

   localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RD  = 2'b01;
   localparam logic [1:0] OP_WR  = 2'b10;
   localparam logic [1:0] OP_REF = 2'b11;

   typedef enum logic [1:0] {IDLE, REF, RD, WR} state_t;

   state_t      state, state_n;
   logic [CW-1:0] ref_cnt;
   logic        ref_wrap;
   logic [1:0]  ref_pend;
   logic        ref_dec;
   logic        wr_aged;

   logic        start_n;
   logic [1:0]  op_n;
   logic [23:0] addr_n;
   logic        rd_gnt_n;
   logic        wr_gnt_n;

   assign ref_wrap = (ref_cnt == CW'(REF_INTERVAL - 1));
   assign busy     = (state != IDLE);

   // Free-running refresh interval counter, restarts from 0 after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ref_cnt <= '0;
      else if (ref_wrap) ref_cnt <= '0;
      else               ref_cnt <= ref_cnt + 1'b1;
   end

   // Refresh backlog: +1 per wrap, -1 per REF entry; a wrap into a full backlog is sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_pend <= 2'd0;
         ref_ovf  <= 1'b0;
      end else begin
         if (ref_wrap && !ref_dec) begin
            if (ref_pend == 2'd3) ref_ovf  <= 1'b1;
            else                  ref_pend <= ref_pend + 2'd1;
         end else if (!ref_wrap && ref_dec) begin
            ref_pend <= ref_pend - 2'd1;
         end
      end
   end

`ifdef SDRAM_ARB_WR_AGE_EN
   localparam int AW = $clog2(WR_MAX_WAIT + 1);
   logic [AW-1:0] age_cnt;

   // Counts reads granted ahead of a waiting write; saturates at the promotion threshold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                              age_cnt <= '0;
      else if (wr_gnt_n)                                       age_cnt <= '0;
      else if (rd_gnt_n && wr_req && age_cnt < AW'(WR_MAX_WAIT)) age_cnt <= age_cnt + 1'b1;
   end

   assign wr_aged = wr_req && (age_cnt >= AW'(WR_MAX_WAIT));
`else
   assign wr_aged = 1'b0;
`endif

   // State register and registered launch/grant outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         seq_start <= 1'b0;
         seq_op    <= OP_NOP;
         seq_addr  <= '0;
         rd_gnt    <= 1'b0;
         wr_gnt    <= 1'b0;
      end else begin
         state     <= state_n;
         seq_start <= start_n;
         seq_op    <= op_n;
         seq_addr  <= addr_n;
         rd_gnt    <= rd_gnt_n;
         wr_gnt    <= wr_gnt_n;
      end
   end

   // Next-state selection: refresh, then (aged) write, then read, then write; busy states wait for seq_done.
   always_comb begin
      state_n  = state;
      start_n  = 1'b0;
      op_n     = OP_NOP;
      addr_n   = seq_addr;
      rd_gnt_n = 1'b0;
      wr_gnt_n = 1'b0;
      ref_dec  = 1'b0;
      case (state)
         IDLE: begin
            if (ref_pend != 2'd0) begin
               state_n = REF;
               start_n = 1'b1;
               op_n    = OP_REF;
               addr_n  = '0;
               ref_dec = 1'b1;
            end else if (wr_aged) begin
               state_n  = WR;
               start_n  = 1'b1;
               op_n     = OP_WR;
               addr_n   = wr_addr;
               wr_gnt_n = 1'b1;
            end else if (rd_req) begin
               state_n  = RD;
               start_n  = 1'b1;
               op_n     = OP_RD;
               addr_n   = rd_addr;
               rd_gnt_n = 1'b1;
            end else if (wr_req) begin
               state_n  = WR;
               start_n  = 1'b1;
               op_n     = OP_WR;
               addr_n   = wr_addr;
               wr_gnt_n = 1'b1;
            end
         end
         REF, RD, WR: begin
            if (seq_done) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sdram_arb.sv
// tb/tb_sdram_arb.sv - directed self-checking bench for sdram_arb
module tb_sdram_arb;

   logic        clk;
   logic        rst_n;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_gnt;
   logic        wr_req;
   logic [23:0] wr_addr;
   logic        wr_gnt;
   logic        seq_start;
   logic [1:0]  seq_op;
   logic [23:0] seq_addr;
   logic        seq_done;
   logic        busy;
   logic        ref_ovf;

   int checks;
   int failures;
   int n;
   logic [1:0] exp_seq [7];

   sdram_arb #(.REF_INTERVAL(16), .WR_MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .wr_req    (wr_req),
      .wr_addr   (wr_addr),
      .wr_gnt    (wr_gnt),
      .seq_start (seq_start),
      .seq_op    (seq_op),
      .seq_addr  (seq_addr),
      .seq_done  (seq_done),
      .busy      (busy),
      .ref_ovf   (ref_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Reset is released on a falling edge, so the next rising edge is edge 1.
   task automatic reset_dut();
      rst_n    = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      seq_done = 1'b0;
      step(2);
      rst_n = 1'b1;
   endtask

   task automatic done_pulse();
      seq_done = 1'b1;
      step(1);
      seq_done = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rd_addr  = '0;
      wr_addr  = '0;
      rst_n    = 1'b0;
      rd_req   = 1'b0;
      wr_req   = 1'b0;
      seq_done = 1'b0;
      step(2);

      // Reset state
      chk("rst_outputs", {rd_gnt, wr_gnt, seq_start, seq_op, busy, ref_ovf}, 0);
      chk("rst_addr", seq_addr, 0);

      // Read beats write; write follows after seq_done plus one IDLE cycle
      reset_dut();
      rd_req = 1'b1; rd_addr = 24'hA51234;
      wr_req = 1'b1; wr_addr = 24'h3C0FF0;
      step(1);
      chk("rw_rd_gnt", {rd_gnt, wr_gnt}, 2'b10);
      chk("rw_rd_start", {seq_start, seq_op}, 3'b101);
      chk("rw_rd_addr", seq_addr, 24'hA51234);
      chk("rw_busy", busy, 1);
      rd_req = 1'b0; rd_addr = 24'h000000;
      step(1);
      chk("rw_gnt_pulse", {rd_gnt, wr_gnt, seq_start}, 0);
      step(2);
      chk("rw_addr_hold", seq_addr, 24'hA51234);
      done_pulse();
      chk("rw_idle_after_done", {busy, wr_gnt, seq_start}, 0);
      step(1);
      chk("rw_wr_gnt", {rd_gnt, wr_gnt, seq_start, seq_op}, 5'b01110);
      chk("rw_wr_addr", seq_addr, 24'h3C0FF0);
      wr_req = 1'b0;
      done_pulse();

      // Write request dropped before grant is never granted
      reset_dut();
      rd_req = 1'b1; rd_addr = 24'h000100;
      step(1);
      chk("drop_rd_gnt", rd_gnt, 1);
      rd_req = 1'b0;
      wr_req = 1'b1; wr_addr = 24'h777777;
      step(1);
      wr_req = 1'b0;
      n = 0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         if (wr_gnt) n++;
      end
      done_pulse();
      for (int k = 0; k < 4; k++) begin
         step(1);
         if (wr_gnt || seq_start) n++;
      end
      chk("drop_no_wr_gnt", n, 0);

      // Reset asserted while in RD clears everything at once; later seq_done ignored
      reset_dut();
      rd_req = 1'b1; rd_addr = 24'hFFFFFF;
      step(1);
      rd_req = 1'b0;
      step(1);
      chk("midrd_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrd_async_clear", {busy, rd_gnt, wr_gnt, seq_start, seq_op, ref_ovf}, 0);
      chk("midrd_addr_clear", seq_addr, 0);
      step(1);
      rst_n = 1'b1;
      done_pulse();
      chk("midrd_done_ignored", {busy, seq_start}, 0);
      step(1);
      chk("midrd_no_launch", {busy, seq_start, rd_gnt}, 0);

      // First refresh launched after wrap at edge 16, next 16 cycles later
      reset_dut();
      n = 0;
      for (int k = 0; k < 16; k++) begin
         step(1);
         if (seq_start) n++;
      end
      chk("ref_quiet_first", n, 0);
      step(1);
      chk("ref_first_launch", {seq_start, seq_op, busy}, 4'b1111);
      chk("ref_addr_zero", seq_addr, 0);
      done_pulse();
      chk("ref_back_idle", busy, 0);
      n = 0;
      for (int k = 0; k < 14; k++) begin
         step(1);
         if (seq_start) n++;
      end
      chk("ref_quiet_second", n, 0);
      step(1);
      chk("ref_second_launch", {seq_start, seq_op}, 3'b111);
      done_pulse();

      // Refresh outranks a pending read
      reset_dut();
      step(16);
      rd_req = 1'b1; rd_addr = 24'h123456;
      step(1);
      chk("pri_ref_over_rd", {rd_gnt, seq_start, seq_op}, 4'b0111);
      done_pulse();
      step(1);
      chk("pri_rd_after_ref", {rd_gnt, seq_op}, 3'b101);
      chk("pri_rd_addr", seq_addr, 24'h123456);
      rd_req = 1'b0;
      done_pulse();

      // Refresh backlog overflow while seq_done is withheld
      reset_dut();
      step(17);
      chk("ovf_ref_entered", {seq_start, seq_op}, 3'b111);
      step(62);
      chk("ovf_not_yet", ref_ovf, 0);
      step(1);
      chk("ovf_set", ref_ovf, 1);
      done_pulse();
      chk("ovf_sticky", {ref_ovf, busy}, 2'b10);
      step(1);
      chk("ovf_backlog_launch", {seq_start, seq_op}, 3'b111);
      step(5);
      chk("ovf_still_sticky", ref_ovf, 1);
      rst_n = 1'b0;
      #1;
      chk("ovf_cleared_by_reset", ref_ovf, 0);

      // Reads and writes held continuously: grant sequence
      reset_dut();
`ifdef SDRAM_ARB_WR_AGE_EN
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01; exp_seq[3] = 2'b01;
      exp_seq[4] = 2'b10; exp_seq[5] = 2'b01; exp_seq[6] = 2'b01;
`else
      for (int k = 0; k < 7; k++) exp_seq[k] = 2'b01;
`endif
      rd_req = 1'b1; rd_addr = 24'h0000AA;
      wr_req = 1'b1; wr_addr = 24'h0000BB;
      for (int k = 0; k < 7; k++) begin
         step(1);
         chk($sformatf("age_grant_%0d", k), {wr_gnt, rd_gnt}, exp_seq[k]);
         done_pulse();
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 Parameter REF_INTERVAL, default 1500, is the number of clk cycles between refresh requests.
REQ-002 Parameter WR_MAX_WAIT, default 4, is the number of read grants a pending write tolerates before promotion (used only with aging enabled).
REQ-003 clk  input  1  single clock for all logic, SDRAM controller domain.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rd_req  input  1  display-side burst read request, held until granted.
REQ-006 rd_addr  input  24  read burst start address {bank[1:0], row[12:0], col[8:0]}.
REQ-007 rd_gnt  output  1  one-cycle pulse: read burst accepted.
REQ-008 wr_req  input  1  capture-side burst write request, held until granted.
REQ-009 wr_addr  input  24  write burst start address, same format as rd_addr.
REQ-010 wr_gnt  output  1  one-cycle pulse: write burst accepted.
REQ-011 seq_start  output  1  one-cycle pulse launching the command sequencer.
REQ-012 seq_op  output  2  00 NOP, 01 READ, 10 WRITE, 11 AUTOREF; valid with seq_start.
REQ-013 seq_addr  output  24  burst address; valid with seq_start; 0 for AUTOREF.
REQ-014 seq_done  input  1  one-cycle pulse from sequencer: operation (incl. precharge) complete.
REQ-015 busy  output  1  high whenever the arbiter is not in IDLE.
REQ-016 ref_ovf  output  1  sticky flag: refresh backlog saturated.

Function
REQ-017 The FSM SHALL have four states: IDLE, REF, RD, WR.
REQ-018 A free-running refresh counter SHALL count 0..REF_INTERVAL-1 and wrap, incrementing a 2-bit ref_pend backlog on each wrap.
REQ-019 ref_pend SHALL saturate at 3; a wrap while at 3 SHALL set ref_ovf.
REQ-020 In IDLE the arbiter SHALL select by priority: ref_pend>0, then rd_req, then wr_req.
REQ-021 On selection, IDLE SHALL move to REF/RD/WR on the next edge, pulsing seq_start with matching seq_op/seq_addr, plus rd_gnt or wr_gnt, in that same cycle (one-cycle registered latency from request to grant).
REQ-022 seq_addr SHALL be captured from rd_addr/wr_addr on the grant edge and held stable until seq_done.
REQ-023 Entering REF SHALL decrement ref_pend; a simultaneous counter wrap SHALL leave ref_pend unchanged.
REQ-024 REF/RD/WR SHALL return to IDLE on seq_done; no new seq_start is issued in the seq_done cycle, so consecutive launches are at least two cycles apart.
REQ-025 Requests deasserted before grant SHALL be dropped without a grant; at most one grant SHALL ever be high per cycle.
REQ-026 seq_done received in IDLE SHALL be ignored.

Reset
REQ-027 Asserting rst_n low at any time, including mid-operation, SHALL force IDLE and clear the refresh counter, ref_pend, ref_ovf, the aging counter, and all outputs to 0.
REQ-028 After rst_n rises, the first refresh request SHALL occur REF_INTERVAL cycles later.

Configuration
REQ-029 With SDRAM_ARB_WR_AGE_EN defined, a wait counter SHALL count read grants issued while wr_req is held ungranted; at WR_MAX_WAIT, write SHALL outrank read (refresh still first), and the counter SHALL clear on wr_gnt.
REQ-030 Without SDRAM_ARB_WR_AGE_EN, priority is strictly refresh > read > write and no aging logic is present.

Verification
REQ-031 rd_req and wr_req both high in IDLE, no refresh pending -> rd_gnt pulse with seq_op=01 and seq_addr=rd_addr; wr_gnt only after seq_done plus one IDLE cycle.
REQ-032 REF_INTERVAL=16, no requests -> seq_op=11 pulse at cycle 16 after reset release, then every 16 cycles once seq_done is returned.
REQ-033 seq_done withheld for 64 cycles with REF_INTERVAL=16 -> ref_pend reaches 3, then ref_ovf=1 at the fourth wrap and stays 1 until reset.
REQ-034 rst_n pulsed low while in RD -> busy=0, all outputs 0 immediately; a later seq_done is ignored.
REQ-035 With SDRAM_ARB_WR_AGE_EN and WR_MAX_WAIT=4, rd_req and wr_req held continuously -> four read grants, then a write grant, then reads resume.
REQ-036 wr_req raised for one cycle while busy, then dropped -> no wr_gnt is issued.
